// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and state encoding for the UART command frame parser.
package uart_cmd_parser_pkg;

    localparam logic [7:0] OPC_READ  = 8'h01;
    localparam logic [7:0] OPC_WRITE = 8'h02;

    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_CHKSUM  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OPCODE = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        ISSUE  = 3'd5
    } parser_state_t;

endpackage

// File: rtl/uart_cmd_parser_gap_timer.sv
// Inter-byte gap counter: cleared by the parser, counts while enabled,
// flags expiry once it has sat at TIMEOUT_CYCLES-1.
module byte_gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expire = enable && (cnt == LAST);

    // Saturates at LAST so a parser that lingers cannot wrap the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != LAST)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Pops bytes from a show-ahead RX FIFO, assembles SYNC/OPCODE/ADDR/DATA/CHK
// frames and issues one register-bus request per good frame.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int          ADDR_W         = 16,
    parameter int          DATA_W         = 32,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        fifo_data,
    input  logic              fifo_valid,
    output logic              fifo_rd_en,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);

    parser_state_t    state, state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       xor_acc;
    logic             pop, in_frame, expire, gap_clear;
    logic             err_set;
    logic [1:0]       err_nxt;

    assign in_frame   = (state == OPCODE) || (state == ADDR) || (state == DATA) || (state == CHECK);
    assign pop        = fifo_valid && (state != ISSUE);
    assign fifo_rd_en = pop;
    assign busy       = (state != IDLE);
    assign gap_clear  = pop || (state_nxt != state) || !in_frame;

    byte_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (gap_clear),
        .enable(in_frame),
        .expire(expire)
    );

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_nxt   = err_code;
        case (state)
            IDLE: begin
                if (pop && fifo_data == SYNC_BYTE)
                    state_nxt = OPCODE;
            end
            OPCODE: begin
                if (pop) begin
                    if (fifo_data == OPC_READ || fifo_data == OPC_WRITE) begin
                        state_nxt = ADDR;
                    end else begin
                        state_nxt = IDLE;
                        err_set   = 1'b1;
                        err_nxt   = ERR_OPCODE;
                    end
                end
            end
            ADDR: begin
                if (pop && byte_cnt == ADDR_LAST)
                    state_nxt = req_write ? DATA : CHECK;
            end
            DATA: begin
                if (pop && byte_cnt == DATA_LAST)
                    state_nxt = CHECK;
            end
            CHECK: begin
                if (pop) begin
                    if (fifo_data == xor_acc) begin
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                        err_set   = 1'b1;
                        err_nxt   = ERR_CHKSUM;
                    end
                end
            end
            ISSUE: begin
                if (req_valid && req_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A byte arriving on the expiry cycle keeps the frame alive.
        if (in_frame && !pop && expire) begin
            state_nxt = IDLE;
            err_set   = 1'b1;
            err_nxt   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= '0;
        end else begin
            state     <= state_nxt;
            req_valid <= (state_nxt == ISSUE);
            err_valid <= err_set;
            err_code  <= err_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= '0;
            xor_acc   <= '0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            if (state_nxt != state)
                byte_cnt <= '0;
            else if (pop && (state == ADDR || state == DATA))
                byte_cnt <= byte_cnt + CNT_W'(1);

            // Fresh frame: drop anything left from the previous one.
            if (state == IDLE && state_nxt == OPCODE) begin
                xor_acc   <= '0;
                req_wdata <= '0;
            end

            if (pop) begin
                case (state)
                    OPCODE: begin
                        req_write <= (fifo_data == OPC_WRITE);
                        xor_acc   <= fifo_data;
                    end
                    ADDR: begin
                        req_addr <= (req_addr << 8) | ADDR_W'(fifo_data);
                        xor_acc  <= xor_acc ^ fifo_data;
                    end
                    DATA: begin
                        req_wdata <= (req_wdata << 8) | DATA_W'(fifo_data);
                        xor_acc   <= xor_acc ^ fifo_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: drives a show-ahead FIFO head and
// checks requests, error strobes and timing against hand-computed values.
module tb_uart_cmd_parser;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  fifo_data = '0;
    logic        fifo_valid = 1'b0;
    logic        fifo_rd_en;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor state
    int          req_cnt = 0, err_cnt = 0, vld_cycles = 0, issue_pops = 0, unstable = 0;
    logic        cap_write;
    logic [15:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        prev_vld = 1'b0, prev_hs = 1'b0, prev_write;
    logic [15:0] prev_addr;
    logic [31:0] prev_wdata;

    logic [7:0]  fq[$];
    int          base_req, base_err;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .ADDR_W(16), .DATA_W(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_rd_en(fifo_rd_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .err_valid(err_valid), .err_code(err_code), .busy(busy)
    );

    always @(negedge clk) begin
        if (req_valid) vld_cycles++;
        if (req_valid && fifo_rd_en) issue_pops++;
        if (req_valid && prev_vld && !prev_hs &&
            (req_write != prev_write || req_addr != prev_addr || req_wdata != prev_wdata))
            unstable++;
        if (req_valid && req_ready) begin
            req_cnt++;
            cap_write = req_write;
            cap_addr  = req_addr;
            cap_wdata = req_wdata;
        end
        if (err_valid) err_cnt++;
        prev_vld   = req_valid;
        prev_hs    = req_valid && req_ready;
        prev_write = req_write;
        prev_addr  = req_addr;
        prev_wdata = req_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte; returns #1 after the edge that popped it.
    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        fifo_valid = 1'b1;
        fifo_data  = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        fifo_valid = 1'b0;
        if (!done) chk("pop_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic send_q();
        while (fq.size() > 0) send_byte(fq.pop_front());
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        idle_cycles(3);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_write", 64'(req_write), 64'd0);
        chk("rst_req_addr", 64'(req_addr), 64'd0);
        chk("rst_req_wdata", 64'(req_wdata), 64'd0);
        chk("rst_err_valid", 64'(err_valid), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        idle_cycles(2);

        // 1: write frame, ready high
        base_req = req_cnt; base_err = err_cnt;
        fq = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h30};
        send_q();
        chk("t1_latency_vld", 64'(req_valid), 64'd1);
        idle_cycles(1);
        chk("t1_vld_drop", 64'(req_valid), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);
        idle_cycles(3);
        chk("t1_req_cnt", 64'(req_cnt - base_req), 64'd1);
        chk("t1_write", 64'(cap_write), 64'd1);
        chk("t1_addr", 64'(cap_addr), 64'h0010);
        chk("t1_wdata", 64'(cap_wdata), 64'hDEADBEEF);
        chk("t1_no_err", 64'(err_cnt - base_err), 64'd0);

        // 2: read frame, ready low for 5 cycles, FIFO non-empty meanwhile
        base_req = req_cnt; vld_cycles = 0; issue_pops = 0;
        req_ready = 1'b0;
        fq = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h21};
        send_q();
        fifo_valid = 1'b1; fifo_data = 8'h00;
        repeat (5) @(posedge clk);
        #1 req_ready = 1'b1;
        idle_cycles(1);
        chk("t2_vld_drop", 64'(req_valid), 64'd0);
        idle_cycles(1);
        fifo_valid = 1'b0;
        idle_cycles(2);
        chk("t2_vld_cycles", 64'(vld_cycles), 64'd6);
        chk("t2_issue_pops", 64'(issue_pops), 64'd0);
        chk("t2_stable", 64'(unstable), 64'd0);
        chk("t2_req_cnt", 64'(req_cnt - base_req), 64'd1);
        chk("t2_addr", 64'(cap_addr), 64'h0020);
        chk("t2_write", 64'(cap_write), 64'd0);
        chk("t2_wdata", 64'(cap_wdata), 64'd0);
        chk("t2_idle", 64'(busy), 64'd0);

        // 3: leading garbage then a write
        base_req = req_cnt; base_err = err_cnt;
        fq = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h02, 8'h00, 8'h10,
               8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h30};
        send_q();
        idle_cycles(3);
        chk("t3_req_cnt", 64'(req_cnt - base_req), 64'd1);
        chk("t3_addr", 64'(cap_addr), 64'h0010);
        chk("t3_wdata", 64'(cap_wdata), 64'hDEADBEEF);
        chk("t3_no_err", 64'(err_cnt - base_err), 64'd0);

        // 4a: bad opcode
        base_err = err_cnt;
        fq = '{8'hA5, 8'h07};
        send_q();
        chk("t4_op_err_valid", 64'(err_valid), 64'd1);
        chk("t4_op_err_code", 64'(err_code), 64'd1);
        chk("t4_op_busy", 64'(busy), 64'd0);
        idle_cycles(1);
        chk("t4_op_strobe_1cyc", 64'(err_valid), 64'd0);
        chk("t4_op_code_hold", 64'(err_code), 64'd1);
        chk("t4_op_err_cnt", 64'(err_cnt - base_err), 64'd1);

        // 4b: bad checksum
        base_req = req_cnt;
        fq = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h22};
        send_q();
        chk("t4_chk_err_valid", 64'(err_valid), 64'd1);
        chk("t4_chk_err_code", 64'(err_code), 64'd2);
        idle_cycles(3);
        chk("t4_chk_no_req", 64'(req_cnt - base_req), 64'd0);
        chk("t4_chk_busy", 64'(busy), 64'd0);

        // 5a: inter-byte timeout
        base_err = err_cnt;
        fq = '{8'hA5, 8'h02, 8'h00};
        send_q();
        repeat (T - 1) @(posedge clk);
        #1;
        chk("t5_no_early_err", 64'(err_valid), 64'd0);
        chk("t5_still_busy", 64'(busy), 64'd1);
        idle_cycles(1);
        chk("t5_err_valid", 64'(err_valid), 64'd1);
        chk("t5_err_code", 64'(err_code), 64'd3);
        chk("t5_idle", 64'(busy), 64'd0);
        idle_cycles(2);

        // 5b: next byte lands exactly on the expiry cycle
        base_req = req_cnt; base_err = err_cnt;
        fq = '{8'hA5, 8'h02, 8'h00};
        send_q();
        repeat (T - 1) @(posedge clk);
        #1;
        fq = '{8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h30};
        send_q();
        idle_cycles(3);
        chk("t5b_no_err", 64'(err_cnt - base_err), 64'd0);
        chk("t5b_req_cnt", 64'(req_cnt - base_req), 64'd1);
        chk("t5b_wdata", 64'(cap_wdata), 64'hDEADBEEF);

        // 6: reset during DATA, then clean read
        base_req = req_cnt; base_err = err_cnt;
        fq = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'hDE, 8'hAD};
        send_q();
        chk("t6_mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_wdata", 64'(req_wdata), 64'd0);
        chk("t6_rst_addr", 64'(req_addr), 64'd0);
        chk("t6_rst_err_code", 64'(err_code), 64'd0);
        chk("t6_rst_write", 64'(req_write), 64'd0);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);
        fq = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h21};
        send_q();
        idle_cycles(3);
        chk("t6_req_cnt", 64'(req_cnt - base_req), 64'd1);
        chk("t6_addr", 64'(cap_addr), 64'h0020);
        chk("t6_write", 64'(cap_write), 64'd0);
        chk("t6_wdata", 64'(cap_wdata), 64'd0);
        chk("t6_no_err", 64'(err_cnt - base_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
